// File: rtl/cnt_pkg.sv
// cnt_pkg: shared state encoding and mode codes for the counter enable generator
package cnt_pkg;
  typedef enum logic [1:0] {IDLE, RUN, BURST, STEP} en_state_t;
  localparam logic [1:0] MODE_RUN   = 2'b00;
  localparam logic [1:0] MODE_BURST = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises a raw button, filters bounces, flags debounced rising edges
module btn_debounce #(
  parameter int DEB_CYC = 16
) (
  input  logic Clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);
  localparam int CW = $clog2(DEB_CYC);
  logic s1, s2, lvl, lvl_d;
  logic [CW-1:0] cnt;
  assign rise = lvl & ~lvl_d;
  // the synchronised level must disagree with lvl for DEB_CYC straight cycles to flip it
  always_ff @(posedge Clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      lvl   <= 1'b0;
      lvl_d <= 1'b0;
      cnt   <= '0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      lvl_d <= lvl;
      if (s2 == lvl) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYC - 1)) begin
        lvl <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/cnt_en_gen.sv
// cnt_en_gen: single-cycle enable pulse source (run, burst, step) for the up-counter
module cnt_en_gen
  import cnt_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int BURST_W = 8,
  parameter int DEB_CYC = 16
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic [1:0]         mode,
  input  logic               start,
  input  logic               stop,
  input  logic [DIV_W-1:0]   div,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               step_btn,
  output logic               en,
  output logic               busy,
  output logic               done
);
  en_state_t state;
  logic [DIV_W-1:0] div_q, div_n, psc, psc_n;
  logic [BURST_W-1:0] len_q, len_n, bcnt, cnt_n;
  logic tick, last, rise;
  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
    .Clk(Clk),
    .reset(reset),
    .btn(step_btn),
    .rise(rise)
  );
  // en is registered, so decide on the prescaler value the next cycle will hold;
  // in IDLE those are the values a start is about to latch
  always_comb begin
    div_n = (state == IDLE) ? div : div_q;
    len_n = (state == IDLE) ? burst_len : len_q;
    cnt_n = (state == IDLE) ? '0 : bcnt;
    psc_n = (state == IDLE || psc == div_q) ? '0 : psc + 1'b1;
    tick  = (psc_n == div_n);
    last  = (cnt_n + 1'b1 == len_n);
  end
  always_ff @(posedge Clk) begin
    if (reset) begin
      state <= IDLE;
      div_q <= '0;
      len_q <= '0;
      psc   <= '0;
      bcnt  <= '0;
      en    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      en   <= 1'b0;
      done <= 1'b0;
      psc  <= psc_n;
      case (state)
        IDLE: begin
          div_q <= div;
          len_q <= burst_len;
          bcnt  <= '0;
          if (start && !stop) begin
            if (mode == MODE_STEP) begin
              state <= STEP;
              busy  <= 1'b1;
            end else if (mode != MODE_BURST) begin
              state <= RUN;
              busy  <= 1'b1;
              en    <= tick;
            end else if (burst_len == '0) begin
              done <= 1'b1;
            end else begin
              state <= BURST;
              busy  <= 1'b1;
              en    <= tick;
              done  <= tick && last;
              if (tick) bcnt <= cnt_n + 1'b1;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            en <= tick;
          end
        end
        BURST: begin
          if (stop || done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            en   <= tick;
            done <= tick && last;
            if (tick) bcnt <= cnt_n + 1'b1;
          end
        end
        STEP: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            en <= rise;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cnt_en_gen.sv
// tb_cnt_en_gen: vector table, random ops against a cycle-index model, step/reset sequences
module tb_cnt_en_gen;
  import cnt_pkg::*;
  localparam int DEB = 16;
  logic Clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] mode = 2'b00;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic [7:0] div = 8'd0;
  logic [7:0] burst_len = 8'd0;
  logic step_btn = 1'b0;
  logic en, busy, done;
  int checks = 0;
  int failures = 0;

  cnt_en_gen #(.DIV_W(8), .BURST_W(8), .DEB_CYC(DEB)) dut (
    .Clk(Clk), .reset(reset), .mode(mode), .start(start), .stop(stop),
    .div(div), .burst_len(burst_len), .step_btn(step_btn),
    .en(en), .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0] m;
    int d;
    int len;
    int s;
    int n;
    int exp_en;
    int exp_done;
  } vec_t;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // {en,busy,done} in cycle k after the start cycle; s = cycle stop is driven (-1 none, 0 with start)
  function automatic logic [2:0] model(input logic [1:0] m, input int d, input int len,
                                       input int s, input int k);
    bit act;
    int f;
    act = (s < 0) || (k <= s);
    if (m == MODE_BURST) begin
      if (len == 0) return {1'b0, 1'b0, act && k == 1};
      f = len * (d + 1);
      act = act && (k <= f);
      return {act && (k % (d + 1) == 0), act, act && (k == f)};
    end
    return {act && (k % (d + 1) == 0), act, 1'b0};
  endfunction

  task automatic run_op(input string name, input logic [1:0] m, input int d, input int len,
                        input int s, input int n, input int exp_en, input int exp_done);
    int ne, nd;
    ne = 0;
    nd = 0;
    mode = m;
    div = d[7:0];
    burst_len = len[7:0];
    start = 1'b1;
    stop = (s == 0);
    tick();
    start = 1'b0;
    stop = 1'b0;
    for (int k = 1; k <= n; k++) begin
      chk($sformatf("%s_c%0d", name, k), {29'd0, en, busy, done}, {29'd0, model(m, d, len, s, k)});
      ne += int'(en);
      nd += int'(done);
      mode = 2'($urandom);
      div = 8'($urandom);
      burst_len = 8'($urandom);
      stop = (k == s);
      tick();
    end
    stop = 1'b0;
    if (exp_en >= 0) begin
      chk({name, "_en"}, ne, exp_en);
      chk({name, "_done"}, nd, exp_done);
    end
    repeat (2) tick();
  endtask

  task automatic hold_btn(input logic v, input int n, inout int ne, inout int nd);
    step_btn = v;
    repeat (n) begin
      tick();
      ne += int'(en);
      nd += int'(done);
    end
  endtask

  task automatic press(input int n, output int ne, output int first);
    ne = 0;
    first = -1;
    step_btn = 1'b1;
    for (int j = 1; j <= n; j++) begin
      tick();
      if (en === 1'b1) begin
        ne++;
        if (first < 0) first = j;
      end
    end
  endtask

  initial begin
    vec_t tbl[11];
    int ne, nd, first;
    tbl[0]  = '{MODE_RUN,   3,   0, 20,  30,   5, 0};
    tbl[1]  = '{MODE_RUN,   0,   0, 10,  15,  10, 0};
    tbl[2]  = '{MODE_BURST, 1,   5, -1,  20,   5, 1};
    tbl[3]  = '{MODE_BURST, 1,   0, -1,   5,   0, 1};
    tbl[4]  = '{2'b11,      2,   0,  9,  15,   3, 0};
    tbl[5]  = '{MODE_BURST, 1,  10,  6,  30,   3, 0};
    tbl[6]  = '{MODE_RUN,   2,   0,  0,  10,   0, 0};
    tbl[7]  = '{MODE_BURST, 0,   0,  0,   5,   0, 0};
    tbl[8]  = '{MODE_BURST, 0,   1, -1,   5,   1, 1};
    tbl[9]  = '{MODE_BURST, 255, 2, -1, 520,   2, 1};
    tbl[10] = '{MODE_BURST, 0, 255, -1, 260, 255, 1};

    repeat (3) tick();
    chk("reset_out", {29'd0, en, busy, done}, 0);
    reset = 1'b0;
    ne = 0;
    nd = 0;
    repeat (20) begin
      tick();
      ne += int'(en) + int'(busy);
      nd += int'(done);
    end
    chk("idle_en_busy", ne, 0);
    chk("idle_done", nd, 0);

    foreach (tbl[i])
      run_op($sformatf("vec%0d", i), tbl[i].m, tbl[i].d, tbl[i].len, tbl[i].s, tbl[i].n,
             tbl[i].exp_en, tbl[i].exp_done);

    for (int i = 0; i < 25; i++) begin
      logic [1:0] m;
      int d, len, s, n;
      m = 2'($urandom_range(0, 2));
      if (m == MODE_STEP) m = 2'b11;
      d = int'($urandom_range(0, 6));
      len = int'($urandom_range(0, 6));
      if (m == MODE_BURST) begin
        n = len * (d + 1) + 4;
        s = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, n - 2));
      end else begin
        s = int'($urandom_range(0, 30));
        n = s + 4;
      end
      run_op($sformatf("rnd%0d", i), m, d, len, s, n, -1, -1);
    end

    mode = MODE_STEP;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("step_busy", {31'd0, busy}, 1);
    ne = 0;
    nd = 0;
    repeat (4) begin
      hold_btn(1'b1, 5, ne, nd);
      hold_btn(1'b0, 5, ne, nd);
    end
    hold_btn(1'b0, 10, ne, nd);
    chk("glitch_en", ne, 0);
    press(40, ne, first);
    chk("press1_en", ne, 1);
    chk("press1_lat", first, 2 + DEB + 1);
    ne = 0;
    hold_btn(1'b0, 40, ne, nd);
    chk("release_en", ne, 0);
    press(40, ne, first);
    chk("press2_en", ne, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("step_stop_busy", {31'd0, busy}, 0);

    mode = MODE_STEP;
    start = 1'b1;
    tick();
    start = 1'b0;
    ne = 0;
    hold_btn(1'b1, 30, ne, nd);
    hold_btn(1'b0, 30, ne, nd);
    chk("held_entry_en", ne, 0);
    press(40, ne, first);
    chk("repress_en", ne, 1);
    step_btn = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    ne = 0;
    hold_btn(1'b0, 30, ne, nd);
    chk("step_done", nd, 0);
    chk("after_step_en", ne, 0);

    mode = MODE_BURST;
    div = 8'd1;
    burst_len = 8'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    ne = 0;
    for (int k = 1; k <= 4; k++) begin
      ne += int'(en);
      if (k < 4) tick();
    end
    chk("pre_reset_en", ne, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_reset_out", {29'd0, en, busy, done}, 0);
    ne = 0;
    nd = 0;
    repeat (20) begin
      tick();
      ne += int'(en);
      nd += int'(done);
    end
    chk("post_reset_en", ne, 0);
    chk("post_reset_done", nd, 0);
    run_op("burst8_fresh", MODE_BURST, 1, 8, -1, 20, 8, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
